// File: rtl/keys_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keys_debounce                                                   |
// | Purpose  : Per-key 2-flop synchronizer and stability-counter debouncer     |
// |            for push-button pads. Produces clean active-high key levels     |
// |            plus registered one-cycle press/release pulses.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module keys_debounce #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] keys_raw,
   output logic [WIDTH-1:0] keys_out,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic             any_event
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Inversion mask so that a 1 always means "pressed" after normalization.
   localparam logic [WIDTH-1:0] INV_MASK = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] st_q, st_d;
   logic [WIDTH-1:0] press_q, press_d;
   logic [WIDTH-1:0] release_q, release_d;
   logic             any_event_q, any_event_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Synchronizer next-state: normalize polarity, then shift through two stages.
   always_comb begin
      s1_d = keys_raw ^ INV_MASK;
      s2_d = s1_q;
   end

   // Per-key debounce: count consecutive mismatching cycles, accept at terminal count.
   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (s2_q[i] == st_q[i]) begin
            // Any return to the stable level restarts the full interval.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            st_d[i]  = s2_q[i];
            cnt_d[i] = '0;
            if (s2_q[i]) begin
               press_d[i] = 1'b1;
            end else begin
               release_d[i] = 1'b1;
            end
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      any_event_d = |(press_d | release_d);
   end

   // State register; reset wins over any transition due on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q        <= '0;
         s2_q        <= '0;
         st_q        <= '0;
         press_q     <= '0;
         release_q   <= '0;
         any_event_q <= 1'b0;
         cnt_q       <= '{default: '0};
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         st_q        <= st_d;
         press_q     <= press_d;
         release_q   <= release_d;
         any_event_q <= any_event_d;
         cnt_q       <= cnt_d;
      end
   end

   assign keys_out      = st_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign any_event     = any_event_q;

endmodule
`default_nettype wire
